// File: rtl/lot_pkg.sv
// Shared types, widths and BCD helpers for the parking-lot occupancy controller.
package lot_pkg;

    localparam int BCD_W = 4;
    localparam int CNT_W = 10;

    localparam logic [BCD_W-1:0] DIG_FULL = 4'hF;
    localparam logic [BCD_W-1:0] DIG_OFF  = 4'h0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } lot_state_t;

    typedef struct packed {
        logic [BCD_W-1:0] d2;
        logic [BCD_W-1:0] d1;
        logic [BCD_W-1:0] d0;
    } bcd3_t;

    // One BCD count step with ripple carry (up) or borrow (down) across three digits.
    function automatic bcd3_t bcd3_step(input bcd3_t v, input logic up);
        bcd3_t r;
        r = v;
        if (up) begin
            if (v.d0 != 4'd9) begin
                r.d0 = v.d0 + 4'd1;
            end else begin
                r.d0 = 4'd0;
                if (v.d1 != 4'd9) begin
                    r.d1 = v.d1 + 4'd1;
                end else begin
                    r.d1 = 4'd0;
                    r.d2 = v.d2 + 4'd1;
                end
            end
        end else begin
            if (v.d0 != 4'd0) begin
                r.d0 = v.d0 - 4'd1;
            end else begin
                r.d0 = 4'd9;
                if (v.d1 != 4'd0) begin
                    r.d1 = v.d1 - 4'd1;
                end else begin
                    r.d1 = 4'd9;
                    r.d2 = v.d2 - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] blank_mask(input bcd3_t v, input logic is_full);
        return {!is_full, v.d2 == 4'd0, (v.d2 == 4'd0) && (v.d1 == 4'd0), 1'b0};
    endfunction

endpackage

// File: rtl/lot_occupancy_ctrl_if.sv
// Sensor inputs and display/status outputs of the occupancy controller.
interface lot_occupancy_ctrl_if;
    import lot_pkg::*;

    logic             a;
    logic             b;
    logic [BCD_W-1:0] dig0;
    logic [BCD_W-1:0] dig1;
    logic [BCD_W-1:0] dig2;
    logic [BCD_W-1:0] dig3;
    logic [3:0]       blank;
    logic             full;
    logic             empty;
    logic             enter_tick;
    logic             exit_tick;
    logic             reject;

    modport master (
        output a, b,
        input  dig0, dig1, dig2, dig3, blank, full, empty, enter_tick, exit_tick, reject
    );

    modport slave (
        input  a, b,
        output dig0, dig1, dig2, dig3, blank, full, empty, enter_tick, exit_tick, reject
    );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-sample debouncer for one gate sensor.
module sensor_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int             CW   = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            // The DB_CYCLES-th consecutive differing sample is the one that flips the level.
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lot_occupancy_ctrl.sv
// Gate-sensor passage decoder with a saturating 3-digit BCD occupancy count for the meter display.
module lot_occupancy_ctrl
    import lot_pkg::*;
#(
    parameter int CAPACITY  = 250,
    parameter int DB_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    lot_occupancy_ctrl_if.slave  bus
);

    localparam logic [2:0] ST_IDLE = 3'(IDLE);
    localparam logic [2:0] ST_EN1  = 3'(EN1);
    localparam logic [2:0] ST_EN2  = 3'(EN2);
    localparam logic [2:0] ST_EN3  = 3'(EN3);
    localparam logic [2:0] ST_EX1  = 3'(EX1);
    localparam logic [2:0] ST_EX2  = 3'(EX2);
    localparam logic [2:0] ST_EX3  = 3'(EX3);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic a_clean;
    logic b_clean;

    sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
        .clk   (clk),
        .reset (reset),
        .din   (bus.a),
        .dout  (a_clean)
    );

    sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
        .clk   (clk),
        .reset (reset),
        .din   (bus.b),
        .dout  (b_clean)
    );

    logic [1:0] ab;
    logic [2:0] state;
    logic [2:0] state_nx;
    logic       enter_evt;
    logic       exit_evt;

    assign ab = {a_clean, b_clean};

    // NOTE: every output of this block is assigned a default first, so no latch is inferred.
    always_comb begin
        state_nx  = state;
        enter_evt = 1'b0;
        exit_evt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ab == 2'b10)      state_nx = ST_EN1;
                else if (ab == 2'b01) state_nx = ST_EX1;
            end
            ST_EN1: begin
                if (ab == 2'b11)      state_nx = ST_EN2;
                else if (ab == 2'b00) state_nx = ST_IDLE;
            end
            ST_EN2: begin
                if (ab == 2'b01)      state_nx = ST_EN3;
                else if (ab == 2'b10) state_nx = ST_EN1;
            end
            ST_EN3: begin
                if (ab == 2'b00) begin
                    state_nx  = ST_IDLE;
                    enter_evt = 1'b1;
                end else if (ab == 2'b11) begin
                    state_nx  = ST_EN2;
                end
            end
            ST_EX1: begin
                if (ab == 2'b11)      state_nx = ST_EX2;
                else if (ab == 2'b00) state_nx = ST_IDLE;
            end
            ST_EX2: begin
                if (ab == 2'b10)      state_nx = ST_EX3;
                else if (ab == 2'b01) state_nx = ST_EX1;
            end
            ST_EX3: begin
                if (ab == 2'b00) begin
                    state_nx = ST_IDLE;
                    exit_evt = 1'b1;
                end else if (ab == 2'b11) begin
                    state_nx = ST_EX2;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    bcd3_t            bcd;
    bcd3_t            bcd_nx;
    logic             inc;
    logic             dec;
    logic             rej;
    logic             full_nx;

    // Binary and BCD copies move together; the binary one makes the saturation compares cheap.
    always_comb begin
        inc     = enter_evt && (cnt != CAP);
        dec     = exit_evt && (cnt != '0);
        rej     = (enter_evt || exit_evt) && !inc && !dec;
        cnt_nx  = cnt;
        bcd_nx  = bcd;
        if (inc) begin
            cnt_nx = cnt + CNT_W'(1);
            bcd_nx = bcd3_step(bcd, 1'b1);
        end else if (dec) begin
            cnt_nx = cnt - CNT_W'(1);
            bcd_nx = bcd3_step(bcd, 1'b0);
        end
        full_nx = (cnt_nx == CAP);
    end

    logic             enter_q;
    logic             exit_q;
    logic             reject_q;
    logic             full_q;
    logic             empty_q;
    logic [BCD_W-1:0] dig3_q;
    logic [3:0]       blank_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bcd      <= '0;
            enter_q  <= 1'b0;
            exit_q   <= 1'b0;
            reject_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dig3_q   <= DIG_OFF;
            blank_q  <= 4'b1110;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bcd      <= bcd_nx;
            enter_q  <= inc;
            exit_q   <= dec;
            reject_q <= rej;
            full_q   <= full_nx;
            empty_q  <= (cnt_nx == '0);
            dig3_q   <= full_nx ? DIG_FULL : DIG_OFF;
            blank_q  <= blank_mask(bcd_nx, full_nx);
        end
    end

    assign bus.dig0       = bcd.d0;
    assign bus.dig1       = bcd.d1;
    assign bus.dig2       = bcd.d2;
    assign bus.dig3       = dig3_q;
    assign bus.blank      = blank_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.enter_tick = enter_q;
    assign bus.exit_tick  = exit_q;
    assign bus.reject     = reject_q;

endmodule
